logicnet_layer_sequencer: RTL and testbench

// Time-multiplexed evaluator for one LogicNet layer. Neuron truth tables sit in a shared

---
 rtl/logicnet_layer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_logicnet_layer_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : logicnet_layer_sequencer
//  Purpose  : Time-multiplexed evaluator for one LogicNet layer. For each
//             accepted input vector, every neuron is evaluated in turn.
//             Its FANIN input bits are gathered through a programmable
//             connection table. The gathered bits, together with the neuron
//             index, address a shared external truth-table ROM. The 1-bit
//             ROM answers are assembled into an N-bit layer output.
//  Ports    : clk, rst            - clock (rising edge), synchronous active-high reset
//             in_valid/in_ready   - input vector handshake, in_data = vector
//             cfg_we/addr/sel     - connection-table write {neuron, slot} <= sel
//             cfg_err             - 1-cycle pulse when a cfg write is dropped (busy)
//             tt_re/tt_addr       - ROM read strobe and {neuron, gathered bits}
//             tt_rdata            - ROM answer, valid one cycle after tt_re
//             out_valid/out_ready - output handshake, out_data bit n = neuron n
//             busy                - sequencer is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module logicnet_layer_sequencer #(
    parameter  int IN_W   = 64,
    parameter  int N      = 16,
    parameter  int FANIN  = 8,
    localparam int NID_W  = (N > 1) ? $clog2(N) : 1,
    localparam int SEL_W  = (IN_W > 1) ? $clog2(IN_W) : 1,
    localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    cfg_we,
    input  logic [NID_W+SLOT_W-1:0] cfg_addr,
    input  logic [SEL_W-1:0]        cfg_sel,
    output logic                    cfg_err,
    output logic                    tt_re,
    output logic [NID_W+FANIN-1:0]  tt_addr,
    input  logic                    tt_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [NID_W-1:0] NID_LAST = NID_W'(N - 1);

    state_t             state_q, state_d;
    logic [NID_W-1:0]   nid_q, nid_d;
    logic [IN_W-1:0]    in_reg_q, in_reg_d;
    logic [SEL_W-1:0]   table_q [N][FANIN];
    logic [SEL_W-1:0]   table_d [N][FANIN];
    logic               rd_pend_q, rd_pend_d;   // a ROM answer arrives this cycle
    logic [NID_W-1:0]   rd_idx_q, rd_idx_d;     // neuron that answer belongs to
    logic [N-1:0]       out_data_q, out_data_d;
    logic               cfg_err_q, cfg_err_d;

    logic [FANIN-1:0]   w_gather;
    logic [SLOT_W-1:0]  w_cfg_slot;
    logic [NID_W-1:0]   w_cfg_nid;
    logic               w_accept;

    assign w_cfg_slot = cfg_addr[SLOT_W-1:0];
    assign w_cfg_nid  = cfg_addr[SLOT_W +: NID_W];

    // Fan-in gather for the neuron currently being issued.
    generate
        for (genvar k = 0; k < FANIN; k++) begin : g_gather
            assign w_gather[k] = in_reg_q[table_q[nid_q][k]];
        end
    endgenerate

    // DONE with out_ready frees the block in the same cycle, so a new vector
    // can be taken during the output handshake; this keeps the period at N+2.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;

    assign tt_re     = (state_q == EVAL);
    assign tt_addr   = tt_re ? {nid_q, w_gather} : '0;
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign cfg_err   = cfg_err_q;

    always_comb begin
        state_d    = state_q;
        nid_d      = nid_q;
        in_reg_d   = in_reg_q;
        table_d    = table_q;
        rd_pend_d  = 1'b0;
        rd_idx_d   = rd_idx_q;
        out_data_d = out_data_q;
        cfg_err_d  = 1'b0;

        // ROM answer for the neuron issued in the previous cycle.
        if (rd_pend_q) begin
            out_data_d[rd_idx_q] = tt_rdata;
        end

        // Table writes only while idle; out-of-range addresses match no entry.
        if (cfg_we) begin
            if (state_q != IDLE) begin
                cfg_err_d = 1'b1;
            end else begin
                for (int n = 0; n < N; n++) begin
                    for (int k = 0; k < FANIN; k++) begin
                        if ((w_cfg_nid == NID_W'(n)) && (w_cfg_slot == SLOT_W'(k))) begin
                            table_d[n][k] = cfg_sel;
                        end
                    end
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    in_reg_d = in_data;
                    nid_d    = '0;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                rd_pend_d = 1'b1;
                rd_idx_d  = nid_q;
                if (nid_q == NID_LAST) begin
                    state_d = DRAIN;
                end else begin
                    nid_d = nid_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        in_reg_d = in_data;
                        nid_d    = '0;
                        state_d  = EVAL;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            nid_q      <= '0;
            in_reg_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
            out_data_q <= '0;
            cfg_err_q  <= 1'b0;
            for (int n = 0; n < N; n++) begin
                for (int k = 0; k < FANIN; k++) begin
                    table_q[n][k] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            nid_q      <= nid_d;
            in_reg_q   <= in_reg_d;
            rd_pend_q  <= rd_pend_d;
            rd_idx_q   <= rd_idx_d;
            out_data_q <= out_data_d;
            cfg_err_q  <= cfg_err_d;
            table_q    <= table_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logicnet_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logicnet_layer_sequencer
//  Purpose  : Self-checking bench for logicnet_layer_sequencer (IN_W=8, N=4,
//             FANIN=2) with an XOR/AND truth-table ROM model. Neuron n reads
//             input bits {2n+1, 2n}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logicnet_layer_sequencer;

    localparam int IN_W  = 8;
    localparam int N     = 4;
    localparam int FANIN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [2:0] cfg_sel;
    logic       cfg_err;
    logic       tt_re;
    logic [3:0] tt_addr;
    logic       tt_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    logic       rom_and;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [3:0] sb[$];

    typedef struct {
        logic       mode;
        logic [7:0] din;
        logic [3:0] dout;
    } vec_t;
    vec_t vecs[8];

    logicnet_layer_sequencer #(.IN_W(IN_W), .N(N), .FANIN(FANIN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_err(cfg_err),
        .tt_re(tt_re), .tt_addr(tt_addr), .tt_rdata(tt_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External ROM: answer one cycle after tt_re, noise otherwise.
    always @(posedge clk) begin
        if (tt_re) tt_rdata <= rom_and ? (tt_addr[1] & tt_addr[0]) : (tt_addr[1] ^ tt_addr[0]);
        else       tt_rdata <= 1'($urandom);
    end

    function automatic logic [3:0] model(input logic [7:0] d, input logic m);
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = m ? (d[2*n] & d[2*n+1]) : (d[2*n] ^ d[2*n+1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp(input string name);
        logic [3:0] e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(name, 32'(out_data), 32'(e));
        end
    endtask

    // Called at posedge+1; returns at a negedge (out_valid high unless timed out).
    task automatic wait_out(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 40) begin
            tick();
            @(negedge clk);
            k++;
        end
        check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic prog_table();
        for (int n = 0; n < N; n++) begin
            for (int k = 0; k < FANIN; k++) begin
                cfg_we   = 1'b1;
                cfg_addr = {2'(n), 1'(k)};
                cfg_sel  = 3'(2 * n + k);
                tick();
            end
        end
        cfg_we = 1'b0;
    endtask

    // Full single-vector transaction with cycle-exact checks; out_ready must be 1.
    task automatic run_vec(input logic [7:0] din, input logic [3:0] exp, input logic zero_tbl);
        logic [3:0] a;
        in_valid = 1'b1;
        in_data  = din;
        sb.push_back(exp);
        @(negedge clk);
        check("accept_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = ~din;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            a = zero_tbl ? {2'(i), din[0], din[0]} : {2'(i), din[2*i+1], din[2*i]};
            check("eval_tt_re", 32'(tt_re), 32'd1);
            check("eval_tt_addr", 32'(tt_addr), 32'(a));
            check("eval_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        @(negedge clk);
        check("drain_tt_re", 32'(tt_re), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        pop_cmp("vec_out_data");
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int outs, acc, last;

        vecs[0] = '{1'b0, 8'b1001_0110, 4'b1111};
        vecs[1] = '{1'b0, 8'h00,        4'b0000};
        vecs[2] = '{1'b0, 8'hFF,        4'b0000};
        vecs[3] = '{1'b0, 8'h1B,        4'b0110};
        vecs[4] = '{1'b1, 8'hFF,        4'b1111};
        vecs[5] = '{1'b1, 8'hC3,        4'b1001};
        vecs[6] = '{1'b1, 8'h5A,        4'b0000};
        vecs[7] = '{1'b1, 8'h3C,        4'b0110};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_sel = '0; out_ready = 1'b1; rom_and = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_tt_re",     32'(tt_re),     32'd0);
        check("rst_tt_addr",   32'(tt_addr),   32'd0);
        check("rst_cfg_err",   32'(cfg_err),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        tick();
        rst = 1'b0;

        prog_table();
        @(negedge clk);
        check("cfg_err_idle", 32'(cfg_err), 32'd0);
        tick();

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            rom_and = vecs[i].mode;
            run_vec(vecs[i].din, vecs[i].dout, 1'b0);
        end

        // Backpressure: hold output 10 cycles, release with a new vector waiting
        rom_and   = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC3;
        sb.push_back(4'b1001);
        @(negedge clk);
        check("bp_accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_out("bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'h9);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            tick();
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        pop_cmp("bp_out_data_hs");
        sb.push_back(4'b0110);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_accepted", 32'(tt_re), 32'd1);
        tick();
        wait_out("bp2");
        pop_cmp("bp2_out_data");
        tick();

        // Config write while evaluating is dropped
        rom_and  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'b1001_0110;
        sb.push_back(4'b1111);
        @(negedge clk);
        check("cfg_busy_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 3'b000;
        cfg_sel  = 3'd7;
        tick();
        cfg_we = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        tick();
        @(negedge clk);
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        tick();
        wait_out("cfgbusy");
        pop_cmp("cfgbusy_out_data");
        tick();

        // Reset in the third EVAL cycle
        rom_and  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        check("rstmid_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy",      32'(busy),      32'd0);
        check("rstmid_in_ready",  32'(in_ready),  32'd1);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_tt_re",     32'(tt_re),     32'd0);
        check("rstmid_out_data",  32'(out_data),  32'd0);
        tick();
        // Cleared table: every slot selects bit 0
        run_vec(8'h01, 4'b1111, 1'b1);
        rom_and = 1'b0;
        run_vec(8'hFF, 4'b0000, 1'b1);

        // Back-to-back stream with out_ready tied high
        prog_table();
        rom_and   = 1'b0;
        out_ready = 1'b1;
        outs = 0; acc = 0; last = -1;
        in_valid = 1'b1;
        in_data  = 8'h1B;
        for (int b = 0; b < 80 && outs < 4; b++) begin
            @(negedge clk);
            if (out_valid) begin
                pop_cmp("b2b_out_data");
                if (last >= 0) check("b2b_period", 32'(cyc - last), 32'(N + 2));
                last = cyc;
                outs++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, rom_and));
                acc++;
            end
            tick();
            in_valid = (acc < 4);
            in_data  = in_data + 8'h37;
        end
        in_valid = 1'b0;
        check("b2b_outputs", 32'(outs), 32'd4);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
